// File: rtl/delta_channel_scheduler.sv
// Shares one 4-bit delta-modulation compare datapath across NUM_CH channels,
// turning tagged samples into ON/OFF spike events over valid/ready streams.
module delta_channel_scheduler #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [3:0]       in_data,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_threshold,
  input  logic             cfg_off_spike,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [CH_W-1:0]  ev_ch,
  output logic [1:0]       ev_spike,
  output logic [CNT_W-1:0] spike_count
);

  // Per-channel prev storage spans the full id space so out-of-range ids never index past the end.
  localparam int unsigned DEPTH = 1 << CH_W;

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_EMIT} state_t;

  state_t            r_state, w_next;
  logic [CH_W-1:0]   r_ch;
  logic [3:0]        r_data;
  logic [3:0]        r_thr;
  logic              r_off;
  logic [3:0]        r_cfg_thr;
  logic              r_cfg_off;
  logic [3:0]        r_prev [DEPTH];
  logic [DEPTH-1:0]  r_init;
  logic [CH_W-1:0]   r_ev_ch;
  logic [1:0]        r_ev_spike;
  logic [CNT_W-1:0]  r_cnt;

  logic [3:0]        w_prev;
  logic [3:0]        w_diff;
  logic              w_rise, w_fall, w_ch_ok, w_on, w_off, w_fire;

  always_comb begin
    w_prev  = r_prev[r_ch];
    w_rise  = r_data > w_prev;
    w_fall  = r_data < w_prev;
    w_diff  = w_rise ? (r_data - w_prev) : (w_prev - r_data);
    w_ch_ok = 32'(r_ch) < NUM_CH;
    w_on    = (w_diff > r_thr) && w_rise;
    w_off   = (w_diff > r_thr) && w_fall && r_off;
    w_fire  = w_ch_ok && r_init[r_ch] && (w_on || w_off);
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_CMP;
      S_CMP:   w_next = w_fire ? S_EMIT : S_IDLE;
      S_EMIT:  if (ev_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign in_ready    = (r_state == S_IDLE);
  assign ev_valid    = (r_state == S_EMIT);
  assign ev_ch       = r_ev_ch;
  assign ev_spike    = r_ev_spike;
  assign spike_count = r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ch       <= '0;
      r_data     <= '0;
      r_thr      <= '0;
      r_off      <= 1'b0;
      r_cfg_thr  <= '0;
      r_cfg_off  <= 1'b0;
      r_init     <= '0;
      r_ev_ch    <= '0;
      r_ev_spike <= '0;
      r_cnt      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_prev[i] <= '0;
    end else begin
      if (cfg_we) begin
        r_cfg_thr <= cfg_threshold;
        r_cfg_off <= cfg_off_spike;
      end
      // Sample snapshots the config registers before any coincident cfg write lands.
      if (r_state == S_IDLE && in_valid) begin
        r_ch   <= in_ch;
        r_data <= in_data;
        r_thr  <= r_cfg_thr;
        r_off  <= r_cfg_off;
      end
      if (r_state == S_CMP && w_ch_ok) begin
        if (!r_init[r_ch]) begin
          r_prev[r_ch] <= r_data;
          r_init[r_ch] <= 1'b1;
        end else if (w_fire) begin
          r_prev[r_ch] <= r_data;
          r_ev_ch      <= r_ch;
          r_ev_spike   <= w_on ? 2'b01 : 2'b10;
        end
      end
      if (r_state == S_EMIT && ev_ready && r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_delta_channel_scheduler.sv
// Directed bench: expected spike events are queued at issue time and checked by
// an independent monitor whenever an event is handed off.
module tb_delta_channel_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_ch;
  logic [3:0] in_data;
  logic       cfg_we;
  logic [3:0] cfg_threshold;
  logic       cfg_off_spike;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_ch;
  logic [1:0] ev_spike;
  logic [7:0] spike_count;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  delta_channel_scheduler #(.NUM_CH(4), .CH_W(2), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_threshold(cfg_threshold), .cfg_off_spike(cfg_off_spike),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ch(ev_ch), .ev_spike(ev_spike),
    .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every handed-off event must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got ch=%0d spike=%0d expected none (t=%0t)",
                 ev_ch, ev_spike, $time);
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("ev_ch", int'(ev_ch), e / 4);
        chk("ev_spike", int'(ev_spike), e % 4);
      end
    end
  end

  task automatic cfg(input logic [3:0] thr, input logic off);
    @(negedge clk);
    cfg_we = 1'b1; cfg_threshold = thr; cfg_off_spike = off;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // exp: 0 = no event, 1 = ON, 2 = OFF. Returns #1 after the handshake edge.
  task automatic send(input logic [1:0] ch, input logic [3:0] d, input int exp,
                      input logic with_cfg = 1'b0, input logic [3:0] thr = '0);
    int budget = 200;
    @(negedge clk);
    in_valid = 1'b1; in_ch = ch; in_data = d;
    if (with_cfg) begin cfg_we = 1'b1; cfg_threshold = thr; end
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      chk("send_timeout", 0, 1);
    end else begin
      if (exp != 0) exp_q.push_back(int'(ch) * 4 + exp);
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
  endtask

  task automatic wait_ev(input string nm);
    int budget = 50;
    while (!ev_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk(nm, int'(ev_valid), 1);
  endtask

  task automatic drain();
    int budget = 100;
    while ((exp_q.size() != 0 || !in_ready) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_ch = '0; in_data = '0;
    cfg_we = 1'b0; cfg_threshold = '0; cfg_off_spike = 1'b0; ev_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_ev_valid", int'(ev_valid), 0);
    chk("rst_ev_ch", int'(ev_ch), 0);
    chk("rst_ev_spike", int'(ev_spike), 0);
    chk("rst_count", int'(spike_count), 0);

    // 1: seed then rising event, latency N+2
    cfg(4'd2, 1'b1);
    send(2'd0, 4'd5, 0);
    drain();
    send(2'd0, 4'd8, 1);
    chk("lat_n1", int'(ev_valid), 0);
    @(posedge clk); #1;
    chk("lat_n2", int'(ev_valid), 1);
    drain();
    chk("count_1", int'(spike_count), 1);

    // 2: falling with off=1, then off=0 leaves prev untouched
    send(2'd1, 4'd10, 0);
    send(2'd1, 4'd6, 2);
    cfg(4'd2, 1'b0);
    send(2'd1, 4'd10, 1);
    send(2'd1, 4'd6, 0);
    send(2'd1, 4'd12, 0);
    drain();

    // 3: strict threshold and thr=15
    cfg(4'd3, 1'b1);
    send(2'd2, 4'd4, 0);
    send(2'd2, 4'd7, 0);
    send(2'd2, 4'd8, 1);
    cfg(4'd15, 1'b1);
    send(2'd3, 4'd0, 0);
    send(2'd3, 4'd15, 0);
    send(2'd3, 4'd0, 0);
    drain();
    chk("count_3", int'(spike_count), 4);

    // 4: backpressure with interleaved channels (prev: 8,10,8,0)
    cfg(4'd2, 1'b1);
    ev_ready = 1'b0;
    fork
      begin
        send(2'd0, 4'd12, 1);
        send(2'd1, 4'd14, 1);
        send(2'd2, 4'd5, 2);
        send(2'd3, 4'd1, 0);
      end
      begin
        wait_ev("bp_ev_seen");
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("bp_in_ready", int'(in_ready), 0);
          chk("bp_ev_valid", int'(ev_valid), 1);
          chk("bp_ev_ch", int'(ev_ch), 0);
          chk("bp_ev_spike", int'(ev_spike), 1);
          chk("bp_count", int'(spike_count), 4);
        end
        ev_ready = 1'b1;
      end
    join
    drain();
    chk("count_4", int'(spike_count), 7);

    // 5: cfg write coincident with handshake uses old threshold (ch0 prev=12)
    cfg(4'd5, 1'b1);
    send(2'd0, 4'd14, 0, 1'b1, 4'd0);
    send(2'd0, 4'd15, 1);
    drain();

    // 6: reset during EMIT, then saturation
    ev_ready = 1'b0;
    send(2'd1, 4'd0, 0);
    wait_ev("emit_before_rst");
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_emit_ev_valid", int'(ev_valid), 0);
    chk("rst_emit_count", int'(spike_count), 0);
    reset = 1'b0; ev_ready = 1'b1;
    cfg(4'd2, 1'b1);
    send(2'd1, 4'd3, 0);
    send(2'd1, 4'd9, 1);
    drain();
    chk("count_after_rst", int'(spike_count), 1);

    cfg(4'd0, 1'b1);
    send(2'd0, 4'd0, 0);
    for (int i = 0; i < 260; i++) begin
      if (i % 2 == 0) send(2'd0, 4'd1, 1);
      else            send(2'd0, 4'd0, 2);
    end
    drain();
    chk("count_sat", int'(spike_count), 255);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
